// File: rtl/line_fill_unit_pkg.sv
// Shared types and constants for the line fill unit and its counter.
// Line geometry is fixed at four 32-bit words (16-byte lines).
package line_fill_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } lfu_state_e;

  localparam int         WORDS_PER_LINE = 4;
  localparam int         WORD_BITS      = 32;
  localparam int         LINE_BITS      = 128;
  // Replaces the byte offset within a line when forming the line base.
  localparam logic [3:0] OFFSET_MASK    = 4'b0000;

endpackage

// File: rtl/line_fill_unit_if.sv
// Miss request, memory read and line hand-off signals of the line fill unit.
// The slave modport is the fill unit; the master modport is its environment.
interface line_fill_unit_if
  import line_fill_unit_pkg::*;
#(
  parameter int ADDR_W = 32
);

  logic                 Start;
  logic [ADDR_W-1:0]    MissAddr;
  logic                 MemRd;
  logic [ADDR_W-1:0]    MemAddr;
  logic [WORD_BITS-1:0] MemData;
  logic                 MemValid;
  logic [ADDR_W-1:0]    LineAddr;
  logic [LINE_BITS-1:0] LineData;
  logic                 LineValid;
  logic                 LineReady;
  logic                 Busy;

  modport master (
    output Start, MissAddr, MemData, MemValid, LineReady,
    input  MemRd, MemAddr, LineAddr, LineData, LineValid, Busy
  );

  modport slave (
    input  Start, MissAddr, MemData, MemValid, LineReady,
    output MemRd, MemAddr, LineAddr, LineData, LineValid, Busy
  );

endinterface

// File: rtl/line_fill_unit_fill_word_counter.sv
// Word index within the line being filled: synchronous clear, wrapping increment.
// Zero latency on the terminal flag; the count advances only on inc.
module fill_word_counter #(
  parameter int WORDS = 4,
  parameter int CNT_W = $clog2(WORDS)
) (
  input  logic             CLK,
  input  logic             CLR_N,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  assign last = (cnt == CNT_W'(WORDS - 1));

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/line_fill_unit.sv
// Fetches a 4-word line on a miss and holds it for the cache; Start to LineValid >= 5 cycles.
// Memory stalls via MemValid=0; the line is held until LineReady, Start is ignored while busy.
module line_fill_unit #(
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 32
) (
  input logic             CLK,
  input logic             CLR_N,
  line_fill_unit_if.slave lfu
);

  import line_fill_unit_pkg::*;

  localparam int CNT_W = $clog2(WORDS_PER_LINE);

  lfu_state_e                               state;
  logic [ADDR_W-1:0]                        base;
  logic [WORDS_PER_LINE-1:0][WORD_BITS-1:0] line;
  logic                                     mem_rd;
  logic                                     line_vld;
  logic                                     busy;

  logic [CNT_W-1:0] cnt;
  logic             cnt_last;
  logic             cnt_clr;
  logic             cnt_inc;

  assign cnt_clr = (state == IDLE) && lfu.Start;
  assign cnt_inc = (state == FETCH) && lfu.MemValid;

  fill_word_counter #(
    .WORDS (WORDS_PER_LINE)
  ) u_cnt (
    .CLK   (CLK),
    .CLR_N (CLR_N),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .cnt   (cnt),
    .last  (cnt_last)
  );

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state    <= IDLE;
      base     <= '0;
      line     <= '0;
      mem_rd   <= 1'b0;
      line_vld <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (lfu.Start) begin
            base   <= lfu.MissAddr & {{(ADDR_W-4){1'b1}}, OFFSET_MASK};
            mem_rd <= 1'b1;
            busy   <= 1'b1;
            state  <= FETCH;
          end
        end
        FETCH: begin
          if (lfu.MemValid) begin
            line[cnt] <= lfu.MemData;
            if (cnt_last) begin
              mem_rd   <= 1'b0;
              line_vld <= 1'b1;
              state    <= HOLD;
            end
          end
        end
        HOLD: begin
          // Start is deliberately not looked at here, even on the transfer edge.
          if (lfu.LineReady) begin
            line_vld <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign lfu.MemRd     = mem_rd;
  assign lfu.MemAddr   = base + {{(ADDR_W-CNT_W-2){1'b0}}, cnt, 2'b00};
  assign lfu.LineAddr  = base;
  assign lfu.LineData  = line;
  assign lfu.LineValid = line_vld;
  assign lfu.Busy      = busy;

endmodule

// File: doc/line_fill_unit.md
LINE_FILL_UNIT -- requirements
Module: line_fill_unit

Interface
REQ-001 SHALL have parameter WORDS_PER_LINE, default 4, number of 32-bit words per cache line (fixed at 4 in this revision).
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have port CLK  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port CLR_N  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port Start  input  1  miss request; sampled only in IDLE.
REQ-006 SHALL have port MissAddr  input  32  byte address of the missing word.
REQ-007 SHALL have port MemRd  output  1  memory read strobe, high while a word is outstanding.
REQ-008 SHALL have port MemAddr  output  32  word address presented to memory.
REQ-009 SHALL have port MemData  input  32  read data from memory.
REQ-010 SHALL have port MemValid  input  1  MemData valid this cycle; ignored unless MemRd=1.
REQ-011 SHALL have port LineAddr  output  32  line-aligned address of the assembled line (bits [3:0]=0).
REQ-012 SHALL have port LineData  output  128  assembled line; word k in bits [32k+31:32k].
REQ-013 SHALL have port LineValid  output  1  line complete and held for the cache.
REQ-014 SHALL have port LineReady  input  1  cache accepts line; transfer when LineValid and LineReady both high.
REQ-015 SHALL have port Busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, HOLD.
REQ-017 IDLE: Start=1 SHALL latch base = {MissAddr[31:4],4'b0000}, clear word counter to 0, and enter FETCH next cycle.
REQ-018 FETCH: MemRd SHALL be 1 and MemAddr SHALL equal base + 4*cnt (combinational from registered base/cnt).
REQ-019 FETCH with MemValid=1: MemData SHALL be written into line slot cnt at that edge and cnt SHALL increment by 1.
REQ-020 FETCH with MemValid=1 and cnt=3: SHALL enter HOLD; cnt SHALL wrap to 0; MemRd SHALL be 0 from the next cycle.
REQ-021 FETCH with MemValid=0: SHALL stall with no state, counter, or data change, for an unbounded number of cycles.
REQ-022 Minimum latency: Start to LineValid SHALL be 5 cycles (1 to enter FETCH plus 4 words with MemValid held high).
REQ-023 HOLD: LineValid SHALL be 1; LineData and LineAddr SHALL be stable until the transfer.
REQ-024 HOLD with LineReady=1: SHALL return to IDLE next cycle; LineValid SHALL drop.
REQ-025 Start in FETCH or HOLD SHALL be ignored and SHALL not be queued, including when it coincides with the HOLD->IDLE transfer edge.
REQ-026 MissAddr SHALL be ignored outside the IDLE Start edge; changes mid-fill SHALL not affect MemAddr or LineAddr.
REQ-027 Word address arithmetic SHALL be 32-bit; MemAddr[3:0] SHALL only take values 0x0, 0x4, 0x8, 0xC.
REQ-028 The line register SHALL retain its last contents in IDLE; LineData is defined only while LineValid=1.

Reset
REQ-029 CLR_N=0 SHALL asynchronously force: state IDLE, cnt 0, base 0, MemRd 0, LineValid 0, Busy 0, LineAddr 0, LineData 0.
REQ-030 Reset asserted mid-FETCH or mid-HOLD SHALL abort the fill with no line delivered; the first Start after CLR_N rises SHALL be accepted normally.

Structure
REQ-031 A shared package SHALL hold the state enumeration, WORDS_PER_LINE, LINE_BITS=128, and the offset-mask constant 4'b0000.
REQ-032 The word counter with wrap and terminal flag SHALL be a sub-module named fill_word_counter; all other logic SHALL stay in line_fill_unit.

Verification
REQ-033 MissAddr=0x0000_1238, Start pulse, MemValid held 1 -> MemAddr 0x1230, 0x1234, 0x1238, 0x123C on consecutive cycles; LineValid at cycle 5; LineAddr=0x1230.
REQ-034 MemData=0xA0,0xA1,0xA2,0xA3 in order -> LineData=0x000000A3_000000A2_000000A1_000000A0.
REQ-035 MemValid low 3 cycles before word 2 -> MemAddr holds 0x1238 during the stall; LineValid at cycle 8; data is unchanged versus REQ-034.
REQ-036 LineReady held 0 for 4 cycles in HOLD while Start pulses and MissAddr changes -> LineValid stays 1, line is stable, and no new fill starts after the transfer.
REQ-037 CLR_N pulsed low during word 1 of a fill -> all outputs 0 immediately; a new Start with MissAddr=0x40 yields MemAddr sequence 0x40..0x4C.
REQ-038 Back-to-back: LineReady=1 in the first HOLD cycle, Start in the next cycle -> the second fill begins and Busy is low for exactly 1 cycle.
